// File: rtl/vga_scan_driver.sv
// VGA raster generator around a combinational renderer: scan counters, sync decode,
// a HIT_LAT-deep pixel/sync pipeline and a register snapshot taken once per frame.
module vga_scan_driver #(
   parameter int         H_VISIBLE = 800,
   parameter int         H_FRONT   = 56,
   parameter int         H_SYNC    = 120,
   parameter int         H_BACK    = 64,
   parameter int         V_VISIBLE = 600,
   parameter int         V_FRONT   = 37,
   parameter int         V_SYNC    = 6,
   parameter int         V_BACK    = 23,
   parameter bit         SYNC_POS  = 1'b1,
   parameter int         HIT_LAT   = 1,
   parameter logic [8:0] FG_COLOR  = 9'h1FF,
   parameter logic [8:0] BG_COLOR  = 9'h000
) (
   input  logic           clk,
   input  logic           rst,
   output logic [10:0]    x,
   output logic [10:0]    y,
   input  logic           hit,
   input  logic [175:0]   regs_in,
   output logic [175:0]   regs_snap,
   output logic           frame_start,
   output logic           hsync,
   output logic           vsync,
   output logic [8:0]     rgb
);

   localparam int         H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int         V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] SNAP_Y = 11'(V_VISIBLE - 1);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic       SYNC_IDLE = ~SYNC_POS;

   typedef struct packed {
      logic [8:0] pix;
      logic       hs;
      logic       vs;
   } stage_t;

   localparam stage_t IDLE_STAGE = '{pix: 9'h000, hs: SYNC_IDLE, vs: SYNC_IDLE};

   logic [10:0]  x_q, x_d, y_q, y_d;
   logic         run_q;
   logic         fs_q, fs_d;
   logic [175:0] snap_q, snap_d;
   logic         active;
   stage_t       raw;
   stage_t [HIT_LAT-1:0] pipe_q;

   // run_q holds the raster at (0,0) for one extra cycle after reset so that the
   // first post-reset cycle shows x=0,y=0 together with the frame_start pulse.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (run_q) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
         end
      end
      fs_d   = (x_d == '0) && (y_d == '0);
      snap_d = ((x_q == H_LAST) && (y_q == SNAP_Y)) ? regs_in : snap_q;
   end

   // Blanking forces pix to 0 without looking at hit, so an undriven hit never leaks out.
   always_comb begin
      raw    = IDLE_STAGE;
      active = (x_q < H_VIS) && (y_q < V_VIS);
      if (run_q) begin
         if (active) begin
            if (hit) raw.pix = FG_COLOR;
            else     raw.pix = BG_COLOR;
         end
         if ((x_q >= HS_BEG) && (x_q <= HS_END)) raw.hs = SYNC_POS;
         if ((y_q >= VS_BEG) && (y_q <= VS_END)) raw.vs = SYNC_POS;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q    <= '0;
         y_q    <= '0;
         run_q  <= 1'b0;
         fs_q   <= 1'b0;
         snap_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         run_q  <= 1'b1;
         fs_q   <= fs_d;
         snap_q <= snap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < HIT_LAT; i++) pipe_q[i] <= IDLE_STAGE;
      end else begin
         pipe_q[0] <= raw;
         for (int i = 1; i < HIT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = fs_q;
   assign regs_snap   = snap_q;
   assign rgb         = pipe_q[HIT_LAT-1].pix;
   assign hsync       = pipe_q[HIT_LAT-1].hs;
   assign vsync       = pipe_q[HIT_LAT-1].vs;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster: two instances (latency 1 active-high,
// latency 3 active-low) against a cycle model with a per-instance expected-output queue.
module tb_vga_scan_driver;

   localparam int HV = 16, HF = 3, HS = 5, HB = 4, HT = HV + HF + HS + HB;
   localparam int VV = 10, VF = 2, VS = 3, VB = 2, VT = VV + VF + VS + VB;
   localparam logic [8:0] FG1 = 9'h1FF, BG1 = 9'h000, FG3 = 9'h0A5, BG3 = 9'h14A;
   localparam logic [175:0] REG_A = 176'hABCD_0000_5555_0000_0001;

   logic clk = 1'b0, rst = 1'b0, hit = 1'b0;
   logic [175:0] regs_in = '0;
   logic [10:0]  x1, y1, x3, y3;
   logic [175:0] snap1, snap3;
   logic         fs1, fs3, hs1, hs3, vs1, vs3;
   logic [8:0]   rgb1, rgb3;

   always #5 clk = ~clk;

   vga_scan_driver #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POS(1'b1),
      .HIT_LAT(1), .FG_COLOR(FG1), .BG_COLOR(BG1)) dut1 (
      .clk(clk), .rst(rst), .x(x1), .y(y1), .hit(hit), .regs_in(regs_in),
      .regs_snap(snap1), .frame_start(fs1), .hsync(hs1), .vsync(vs1), .rgb(rgb1));

   vga_scan_driver #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POS(1'b0),
      .HIT_LAT(3), .FG_COLOR(FG3), .BG_COLOR(BG3)) dut3 (
      .clk(clk), .rst(rst), .x(x3), .y(y3), .hit(hit), .regs_in(regs_in),
      .regs_snap(snap3), .frame_start(fs3), .hsync(hs3), .vsync(vs3), .rgb(rgb3));

   typedef struct packed { logic [8:0] rgb; logic hs; logic vs; } exp_t;
   typedef struct { int mode; int fg1; int fg3; int vis3; int hs1; int vs1; int hs3; int vs3; } phase_t;

   exp_t q1[$], q3[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;
   int   mx = 0, my = 0;
   bit   mrun = 0, mfs = 0;
   logic [175:0] msnap = '0;
   int   mode = 1;
   bit   counting = 0;
   int   c_fg1, c_fg3, c_vis3, c_hs1, c_vs1, c_hs3, c_vs3, c_fs;

   task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (model x=%0d y=%0d)", nm, act, exp, mx, my);
      end
   endtask

   task automatic pop_chk(input string nm, inout exp_t q[$], input logic [8:0] r,
                          input logic h, input logic v);
      exp_t e;
      if (q.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s_underflow: got empty queue, expected an entry", nm);
      end else begin
         e = q.pop_front();
         chk({nm, "_rgb"}, r, e.rgb);
         chk({nm, "_hs"},  h, e.hs);
         chk({nm, "_vs"},  v, e.vs);
      end
   endtask

   // One clock: advance the model, compare everything, then drive hit and queue its results.
   task automatic step();
      bit r; logic [175:0] rin; int px, py;
      logic h; bit act, hr, vr; exp_t e1, e3;
      @(posedge clk);
      r = rst; rin = regs_in; px = mx; py = my;
      #1;
      cyc++;
      if (!r) begin
         mx = 0; my = 0; mrun = 0; mfs = 0; msnap = '0;
         q1.delete(); q3.delete();
         q1.push_back('{rgb: 9'h0, hs: 1'b0, vs: 1'b0});
         repeat (3) q3.push_back('{rgb: 9'h0, hs: 1'b1, vs: 1'b1});
      end else begin
         if (px == HT-1 && py == VV-1) msnap = rin;
         if (mrun) begin
            if (mx == HT-1) begin mx = 0; my = (my == VT-1) ? 0 : my + 1; end
            else mx++;
         end
         mrun = 1;
         mfs = (mx == 0 && my == 0);
      end
      chk("x1", x1, mx);  chk("y1", y1, my);  chk("x3", x3, mx);  chk("y3", y3, my);
      chk("fs1", fs1, mfs); chk("fs3", fs3, mfs);
      chk("snap1", snap1, msnap); chk("snap3", snap3, msnap);
      pop_chk("d1", q1, rgb1, hs1, vs1);
      pop_chk("d3", q3, rgb3, hs3, vs3);
      if (counting) begin
         c_fg1 += int'(rgb1 === FG1);
         c_fg3 += int'(rgb3 === FG3);
         c_vis3 += int'(rgb3 === FG3 || rgb3 === BG3);
         c_hs1 += int'(hs1 === 1'b1); c_vs1 += int'(vs1 === 1'b1);
         c_hs3 += int'(hs3 === 1'b0); c_vs3 += int'(vs3 === 1'b0);
         c_fs  += int'(fs1 === 1'b1);
      end
      act = mrun && mx < HV && my < VV;
      hr  = mrun && mx >= HV+HF && mx < HV+HF+HS;
      vr  = mrun && my >= VV+VF && my < VV+VF+VS;
      case (mode)
         0:       h = 1'b0;
         1:       h = 1'b1;
         3:       h = 1'($urandom_range(0, 1));
         default: h = act ? 1'($urandom_range(0, 1)) : 1'bx;
      endcase
      hit = h;
      e1.rgb = act ? ((h === 1'b1) ? FG1 : BG1) : 9'h0;
      e3.rgb = act ? ((h === 1'b1) ? FG3 : BG3) : 9'h0;
      e1.hs = hr;  e1.vs = vr;
      e3.hs = !hr; e3.vs = !vr;
      q1.push_back(e1);
      q3.push_back(e3);
   endtask

   task automatic run_to(input int tx, input int ty, input string nm);
      int n;
      n = 0;
      while (!(mx == tx && my == ty) && n < 2*HT*VT) begin step(); n++; end
      chk(nm, (mx == tx && my == ty), 1);
   endtask

   task automatic line_checks();
      int r1[$]; int n; bit p1, p3;
      n = 0; p1 = hs1; p3 = hs3;
      while (r1.size() < 2 && n < 3*HT) begin
         step(); n++;
         if (hs1 && !p1) begin r1.push_back(cyc); chk("hs1_rise_x", x1, HV+HF+1); end
         if (!hs3 && p3) chk("hs3_fall_x", x3, HV+HF+3);
         p1 = hs1; p3 = hs3;
      end
      chk("hs1_rises_seen", r1.size(), 2);
      if (r1.size() == 2) chk("line_period", r1[1] - r1[0], HT);
   endtask

   task automatic frame_checks();
      int f[$]; int n; bit pv1, pv3;
      n = 0; pv1 = vs1; pv3 = vs3;
      while (f.size() < 2 && n < 2*HT*VT + HT) begin
         step(); n++;
         if (fs1) f.push_back(cyc);
         if (vs1 && !pv1) begin chk("vs1_rise_x", x1, 1); chk("vs1_rise_y", y1, VV+VF); end
         if (!vs3 && pv3) begin chk("vs3_fall_x", x3, 3); chk("vs3_fall_y", y3, VV+VF); end
         pv1 = vs1; pv3 = vs3;
      end
      chk("fs_seen", f.size(), 2);
      if (f.size() == 2) chk("frame_period", f[1] - f[0], HT*VT);
   endtask

   task automatic post_release(input string nm);
      chk({nm, "_x"}, x1, 0);    chk({nm, "_y"}, y1, 0);
      chk({nm, "_fs"}, fs1, 1);  chk({nm, "_rgb"}, rgb1, 0);
      chk({nm, "_hs"}, hs1, 0);  chk({nm, "_vs"}, vs1, 0);
      chk({nm, "_hs3"}, hs3, 1); chk({nm, "_vs3"}, vs3, 1);
      chk({nm, "_rgb3"}, rgb3, 0); chk({nm, "_snap"}, snap1, 0);
   endtask

   initial begin
      phase_t ph[4];
      ph[0] = '{mode: 1, fg1: 160, fg3: 160, vis3: 160, hs1: 85, vs1: 84, hs3: 85, vs3: 84};
      ph[1] = '{mode: 0, fg1: 0,   fg3: 0,   vis3: 160, hs1: 85, vs1: 84, hs3: 85, vs3: 84};
      ph[2] = '{mode: 3, fg1: -1,  fg3: -1,  vis3: 160, hs1: 85, vs1: 84, hs3: 85, vs3: 84};
      ph[3] = '{mode: 2, fg1: -1,  fg3: -1,  vis3: 160, hs1: 85, vs1: 84, hs3: 85, vs3: 84};

      // power-on reset with hit held high
      rst = 1'b0; mode = 1; regs_in = REG_A;
      repeat (3) step();
      rst = 1'b1;
      step();
      post_release("por");

      line_checks();

      // snapshot only moves at vblank entry
      run_to(HT-1, VV-1, "reach_vblank0");
      chk("snap_before_vblank", snap1, 0);
      step();
      chk("snap_after_vblank", snap1, REG_A);
      run_to(10, 4, "reach_mid_frame");
      regs_in = 176'h1234;
      run_to(HT-1, VV-1, "reach_vblank1");
      chk("snap_held", snap1, REG_A);
      chk("snap3_held", snap3, REG_A);
      step();
      chk("snap_new", snap1, 176'h1234);
      regs_in = 176'hDEAD;
      run_to(5, VV+VF, "reach_vsync");
      chk("snap_still", snap1, 176'h1234);

      frame_checks();

      // reset mid-frame
      mode = 1;
      run_to(8, 5, "reach_mid_reset");
      rst = 1'b0;
      repeat (3) step();
      chk("in_reset_x", x1, 0);
      chk("in_reset_rgb", rgb1, 0);
      rst = 1'b1;
      step();
      post_release("mid");

      for (int i = 0; i < 4; i++) begin
         mode = ph[i].mode;
         repeat (4) step();
         c_fg1 = 0; c_fg3 = 0; c_vis3 = 0; c_hs1 = 0; c_vs1 = 0; c_hs3 = 0; c_vs3 = 0; c_fs = 0;
         counting = 1;
         repeat (HT*VT) step();
         counting = 0;
         if (ph[i].fg1 >= 0) chk($sformatf("ph%0d_fg1", i), c_fg1, ph[i].fg1);
         if (ph[i].fg3 >= 0) chk($sformatf("ph%0d_fg3", i), c_fg3, ph[i].fg3);
         chk($sformatf("ph%0d_vis3", i), c_vis3, ph[i].vis3);
         chk($sformatf("ph%0d_hs1", i), c_hs1, ph[i].hs1);
         chk($sformatf("ph%0d_vs1", i), c_vs1, ph[i].vs1);
         chk($sformatf("ph%0d_hs3", i), c_hs3, ph[i].hs3);
         chk($sformatf("ph%0d_vs3", i), c_vs3, ph[i].vs3);
         chk($sformatf("ph%0d_fs", i), c_fs, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
